// File: rtl/chunked_eta_adder_ctrl_pkg.sv
// Shared definitions for the chunked error-tolerant adder controller.
//   state_t     : controller FSM states (IDLE, RUN, DONE)
//   num_chunks  : number of CHUNK_WIDTH slices in a TOTAL_WIDTH operand
//   idx_width   : width of the chunk index register, never below 1 bit
package chunked_eta_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int num_chunks(input int total_width, input int chunk_width);
    return total_width / chunk_width;
  endfunction

  function automatic int idx_width(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/chunked_eta_adder_ctrl_slice.sv
// chunk_sum_slice: purely combinational CHUNK_WIDTH adder slice built as a
// generate/propagate ripple chain.
//   a, b : chunk operands
//   cin  : carry into bit 0
//   sum  : chunk sum (modulo 2^CHUNK_WIDTH)
//   cout : carry out of the top bit
module chunk_sum_slice #(
  parameter int CHUNK_WIDTH = 4
) (
  input  logic [CHUNK_WIDTH-1:0] a,
  input  logic [CHUNK_WIDTH-1:0] b,
  input  logic                   cin,
  output logic [CHUNK_WIDTH-1:0] sum,
  output logic                   cout
);

  logic [CHUNK_WIDTH-1:0] gen;
  logic [CHUNK_WIDTH-1:0] prop;
  logic [CHUNK_WIDTH:0]   carry;

  always_comb begin
    gen      = a & b;
    prop     = a ^ b;
    carry    = '0;
    carry[0] = cin;
    for (int unsigned i = 0; i < CHUNK_WIDTH; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
    sum  = prop ^ carry[CHUNK_WIDTH-1:0];
    cout = carry[CHUNK_WIDTH];
  end

endmodule

// File: rtl/chunked_eta_adder_ctrl.sv
// chunked_eta_adder_ctrl: multi-cycle adder that reuses one CHUNK_WIDTH slice,
// one chunk per cycle, LSB chunk first. Carries out of the lowest
// APPROX_CHUNKS chunks are dropped instead of rippled upward.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   valid_i / ready_o   : operand handshake (accepted only in IDLE)
//   input1_i, input2_i  : operands A and B
//   valid_o / ready_i   : result handshake (result held in DONE)
//   sum_o, carry_o      : result register and top-chunk carry-out
//   busy_o              : high in RUN or DONE
//   err_o               : only with CHUNKED_ETA_ERR_FLAG_EN defined; set when
//                         any discarded carry was 1
module chunked_eta_adder_ctrl
  import chunked_eta_pkg::*;
#(
  parameter int TOTAL_WIDTH   = 16,
  parameter int CHUNK_WIDTH   = 4,
  parameter int APPROX_CHUNKS = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [TOTAL_WIDTH-1:0] input1_i,
  input  logic [TOTAL_WIDTH-1:0] input2_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [TOTAL_WIDTH-1:0] sum_o,
  output logic                   carry_o,
  output logic                   busy_o
`ifdef CHUNKED_ETA_ERR_FLAG_EN
  ,
  output logic                   err_o
`endif
);

  localparam int NUM_CHUNKS = num_chunks(TOTAL_WIDTH, CHUNK_WIDTH);
  localparam int IDX_WIDTH  = idx_width(NUM_CHUNKS);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CHUNKS - 1);

  if (TOTAL_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_width
    $error("TOTAL_WIDTH must be a multiple of CHUNK_WIDTH");
  end
  if (APPROX_CHUNKS >= NUM_CHUNKS) begin : g_bad_approx
    $error("APPROX_CHUNKS must be below NUM_CHUNKS");
  end

  state_t                 state;
  state_t                 state_next;
  logic [TOTAL_WIDTH-1:0] op_a;
  logic [TOTAL_WIDTH-1:0] op_b;
  logic [IDX_WIDTH-1:0]   idx;
  logic                   carry_r;
  logic                   accept;
  logic                   last_chunk;
  logic                   approx_chunk;
  logic [CHUNK_WIDTH-1:0] slice_a;
  logic [CHUNK_WIDTH-1:0] slice_b;
  logic [CHUNK_WIDTH-1:0] slice_sum;
  logic                   slice_cin;
  logic                   slice_cout;

  always_comb begin
    last_chunk   = (idx == LAST_IDX);
    approx_chunk = (int'(idx) < APPROX_CHUNKS);
    slice_a      = op_a[int'(idx)*CHUNK_WIDTH +: CHUNK_WIDTH];
    slice_b      = op_b[int'(idx)*CHUNK_WIDTH +: CHUNK_WIDTH];
    slice_cin    = (idx == '0) ? 1'b0 : carry_r;
  end

  chunk_sum_slice #(
    .CHUNK_WIDTH(CHUNK_WIDTH)
  ) u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .cin (slice_cin),
    .sum (slice_sum),
    .cout(slice_cout)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready_o    = 1'b0;
    valid_o    = 1'b0;
    busy_o     = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy_o = 1'b1;
        if (last_chunk) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy_o  = 1'b1;
        valid_o = 1'b1;
        if (ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_a    <= '0;
      op_b    <= '0;
      idx     <= '0;
      carry_r <= 1'b0;
      sum_o   <= '0;
      carry_o <= 1'b0;
`ifdef CHUNKED_ETA_ERR_FLAG_EN
      err_o   <= 1'b0;
`endif
    end else if (accept) begin
      op_a    <= input1_i;
      op_b    <= input2_i;
      idx     <= '0;
      carry_r <= 1'b0;
      sum_o   <= '0;
      carry_o <= 1'b0;
`ifdef CHUNKED_ETA_ERR_FLAG_EN
      err_o   <= 1'b0;
`endif
    end else if (state == RUN) begin
      sum_o[int'(idx)*CHUNK_WIDTH +: CHUNK_WIDTH] <= slice_sum;
      // Approximate chunks drop their carry, both into the next chunk and
      // out of the top chunk.
      carry_r <= approx_chunk ? 1'b0 : slice_cout;
`ifdef CHUNKED_ETA_ERR_FLAG_EN
      err_o   <= err_o | (approx_chunk & slice_cout);
`endif
      if (last_chunk) begin
        carry_o <= approx_chunk ? 1'b0 : slice_cout;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule
